bcd_count_ctrl: RTL and testbench

- Run controller for the two-digit BCD up/down counter: conditions three push-buttons, divides the system clock into count steps, and sequences the counter through idle/run/pause/done.
- Drives the counter's step enable, direction and clear.
- Reads the counter's digits back to detect the terminal value.
- Sits between the board buttons and the counter; the digits also go to the display.

---
 rtl/bcd_count_ctrl.sv | 113 +++++++++++
 tb/tb_bcd_count_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: button-driven idle/run/pause/done sequencer for a two-digit BCD up/down counter.
// Define BCD_COUNT_CTRL_DEBOUNCE_EN to insert a DB_CYCLES stable-counter debouncer on each button.
module bcd_count_ctrl #(
  parameter int TICK_DIV = 50000000,
  parameter int DB_CYCLES = 1000000,
  parameter logic [3:0] LIMIT_10 = 4'd9,
  parameter logic [3:0] LIMIT_1 = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_dir,
  input  logic       btn_clr,
  input  logic [3:0] bcd_1,
  input  logic [3:0] bcd_10,
  output logic       cnt_en,
  output logic       cnt_dir,
  output logic       cnt_clr,
  output logic       done,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, PAUSE = 2'b10, DONE = 2'b11} state_t;
  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  state_t st, st_n;
  logic [PW-1:0] presc, presc_n;
  logic [2:0] s1, s2, lvl, prev, press;
  logic en_n, clr_n, dir_n, tick, term, up_term, dn_term, ps, pd, pc;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      prev <= '0;
    end else begin
      s1 <= {btn_clr, btn_dir, btn_start};
      s2 <= s1;
      prev <= lvl;
    end
`ifdef BCD_COUNT_CTRL_DEBOUNCE_EN
  localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES + 1) : 1;
  logic [DW-1:0] stable [3];
  logic [2:0] db;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      db <= '0;
      for (int i = 0; i < 3; i++) stable[i] <= '0;
    end else
      for (int i = 0; i < 3; i++)
        if (s2[i] == db[i]) stable[i] <= '0;
        else if (stable[i] == DW'(DB_CYCLES - 1)) begin
          db[i] <= s2[i];
          stable[i] <= '0;
        end else stable[i] <= stable[i] + 1'b1;
  assign lvl = db;
`else
  logic unused_db;
  assign unused_db = ^DB_CYCLES;
  assign lvl = s2;
`endif
  assign press = lvl & ~prev;
  assign ps = press[0];
  assign pd = press[1];
  assign pc = press[2];
  assign tick = (st == RUN) && (presc == PW'(TICK_DIV - 1));
  // digits above 9 never match, so a corrupted counter cannot stop the run
  assign up_term = bcd_10 == LIMIT_10 && bcd_1 == LIMIT_1 && bcd_10 <= 4'd9 && bcd_1 <= 4'd9;
  assign dn_term = bcd_10 == 4'd0 && bcd_1 == 4'd0;
  assign term = cnt_dir ? dn_term : up_term;
  always_comb begin
    st_n = st;
    presc_n = presc;
    en_n = 1'b0;
    clr_n = 1'b0;
    dir_n = cnt_dir;
    if (pc) begin
      st_n = IDLE;
      presc_n = '0;
      clr_n = 1'b1;
    end else
      case (st)
        IDLE: begin
          st_n = ps ? RUN : IDLE;
          dir_n = (!ps && pd) ? !cnt_dir : cnt_dir;
        end
        RUN: begin
          presc_n = tick ? '0 : presc + 1'b1;
          en_n = tick && !term;
          st_n = (tick && term) ? DONE : ps ? PAUSE : RUN;
        end
        PAUSE: begin
          st_n = ps ? RUN : PAUSE;
          dir_n = (!ps && pd) ? !cnt_dir : cnt_dir;
        end
        default: st_n = DONE;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      presc <= '0;
      cnt_en <= 1'b0;
      cnt_dir <= 1'b0;
      cnt_clr <= 1'b0;
      done <= 1'b0;
    end else begin
      st <= st_n;
      presc <= presc_n;
      cnt_en <= en_n;
      cnt_dir <= dir_n;
      cnt_clr <= clr_n;
      done <= st_n == DONE;
    end
  assign state = st;
endmodule

// File: tb/tb_bcd_count_ctrl.sv
// tb_bcd_count_ctrl: directed bench with a counter environment and a rule-level reference model.
module tb_bcd_count_ctrl;
  localparam int TICK = 4;
  localparam int DB = 8;
`ifdef BCD_COUNT_CTRL_DEBOUNCE_EN
  localparam int LAT = 3 + DB;
`else
  localparam int LAT = 3;
`endif
  logic clk = 0, rst = 1, btn_start = 0, btn_dir = 0, btn_clr = 0;
  logic [3:0] bcd_1, bcd_10;
  logic cnt_en, cnt_dir, cnt_clr, done;
  logic [1:0] state;
  int val = 0, steps = 0, clrs = 0;
  int vectors = 0, miscompares = 0;

  bcd_count_ctrl #(.TICK_DIV(TICK), .DB_CYCLES(DB), .LIMIT_10(4'd9), .LIMIT_1(4'd9)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .btn_dir(btn_dir), .btn_clr(btn_clr),
    .bcd_1(bcd_1), .bcd_10(bcd_10), .cnt_en(cnt_en), .cnt_dir(cnt_dir), .cnt_clr(cnt_clr),
    .done(done), .state(state));

  always #5 clk = ~clk;

  // decimal counter standing in for the real BCD counter
  assign bcd_10 = 4'(val / 10);
  assign bcd_1 = 4'(val % 10);
  always @(posedge clk or posedge rst)
    if (rst) val <= 0;
    else if (cnt_clr) begin
      val <= 0;
      clrs <= clrs + 1;
    end else if (cnt_en) begin
      val <= cnt_dir ? (val + 99) % 100 : (val + 1) % 100;
      steps <= steps + 1;
    end

  // reference model: button history -> press events -> run rules
  logic [1:0] m_st;
  logic m_en, m_clr, m_dir, m_term, m_tick, all_diff;
  int m_ph;
  logic [63:0] mh [3];
  logic mdb [3], mrose [3], mp [3];
  always @(posedge clk or posedge rst)
    if (rst) begin
      m_st = 0; m_en = 0; m_clr = 0; m_dir = 0; m_ph = 0;
      for (int i = 0; i < 3; i++) begin mh[i] = 0; mdb[i] = 0; mrose[i] = 0; mp[i] = 0; end
    end else begin
      for (int i = 0; i < 3; i++) begin
`ifdef BCD_COUNT_CTRL_DEBOUNCE_EN
        mp[i] = mrose[i];
        all_diff = 1;
        for (int k = 1; k <= DB; k++) if (mh[i][k] == mdb[i]) all_diff = 0;
        mrose[i] = all_diff && !mdb[i];
        if (all_diff) mdb[i] = !mdb[i];
`else
        mp[i] = mh[i][1] && !mh[i][2];
`endif
        mh[i] = {mh[i][62:0], (i == 0) ? btn_start : (i == 1) ? btn_dir : btn_clr};
      end
      m_tick = m_st == 1 && m_ph == TICK - 1;
      m_term = m_dir ? (val == 0) : (bcd_10 <= 9 && bcd_1 <= 9 && int'(bcd_10) * 10 + int'(bcd_1) == 99);
      m_en = 0;
      m_clr = 0;
      if (mp[2]) begin m_clr = 1; m_st = 0; m_ph = 0; end
      else case (m_st)
        0: if (mp[0]) begin m_st = 1; m_ph = 0; end else if (mp[1]) m_dir = !m_dir;
        1: begin
          if (m_tick && m_term) m_st = 3;
          else begin m_en = m_tick; if (mp[0]) m_st = 2; end
          m_ph = m_tick ? 0 : m_ph + 1;
        end
        2: if (mp[0]) m_st = 1; else if (mp[1]) m_dir = !m_dir;
        default: ;
      endcase
    end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (!rst) check("cycle {state,done,en,dir,clr}", {27'd0, state, done, cnt_en, cnt_dir, cnt_clr},
                      {27'd0, m_st, m_st == 2'b11, m_en, m_dir, m_clr});
    end
  endtask

  task automatic press(input logic [2:0] m);
    {btn_clr, btn_dir, btn_start} = m;
    step(LAT + 1);
    {btn_clr, btn_dir, btn_start} = 3'b000;
    step(LAT + 2);
  endtask

  task automatic wait_state(input logic [1:0] s, input int lim, input string nm);
    int k = 0;
    while (state !== s && k < lim) begin step(1); k++; end
    check(nm, {30'd0, state}, {30'd0, s});
  endtask

  task automatic wait_en(input int lim);
    int k = 0;
    while (cnt_en !== 1'b1 && k < lim) begin step(1); k++; end
    check("wait_cnt_en", {31'd0, cnt_en}, 1);
  endtask

  initial begin
    int k, s0, c0, pv;
    step(3);
    rst = 0;
    step(1);
    check("reset_outputs", {27'd0, state, done, cnt_en, cnt_dir, cnt_clr}, 0);
`ifdef BCD_COUNT_CTRL_DEBOUNCE_EN
    btn_start = 1; step(5); btn_start = 0; step(20);
    check("glitch_no_run", {30'd0, state}, 0);
`endif
    btn_start = 1;
    k = 0;
    while (state !== 2'b01 && k < 40) begin step(1); k++; end
    check("start_latency", k, LAT);
    step(1);
    btn_start = 0;
    step(LAT + 2);
    check("single_run_entry", {30'd0, state}, 1);
    wait_state(2'b11, 1000, "up_reaches_done");
    check("up_steps", steps, 99);
    check("up_final_value", val, 99);
    check("done_flag", {31'd0, done}, 1);
    press(3'b100);
    check("clr_to_zero", val, 0);
    press(3'b001);
    wait_en(50);
    step(3);
    press(3'b001);
    check("paused", {30'd0, state}, 2);
    pv = val;
    step(20);
    check("pause_holds_value", val, pv);
    btn_start = 1;
    wait_state(2'b01, 40, "resume_run");
    k = 0;
    while (cnt_en !== 1'b1 && k < 20) begin step(1); k++; end
    check("resume_partial_gap", k, TICK - 2);
    step(1);
    check("resume_next_value", val, pv + 1);
    btn_start = 0;
    step(LAT + 2);
    press(3'b001);
    press(3'b010);
    check("pause_dir_toggle", {31'd0, cnt_dir}, 1);
    c0 = val;
    s0 = steps;
    press(3'b001);
    wait_state(2'b11, 1000, "down_reaches_done");
    check("down_final_value", val, 0);
    check("down_steps", steps - s0, c0);
    press(3'b100);
    check("done_clr_idle", {30'd0, state}, 0);
    s0 = steps;
    press(3'b001);
    wait_state(2'b11, 50, "down_from_zero_done");
    check("down_zero_steps", steps - s0, 0);
    press(3'b100);
    press(3'b010);
    check("idle_dir_toggle", {31'd0, cnt_dir}, 0);
    press(3'b001);
    press(3'b010);
    check("run_dir_ignored", {31'd0, cnt_dir}, 0);
    c0 = clrs;
    press(3'b101);
    check("clr_beats_start", {30'd0, state}, 0);
    check("clr_single_pulse", clrs - c0, 1);
    press(3'b010);
    press(3'b001);
    wait_state(2'b11, 50, "done_again");
    press(3'b001);
    check("done_ignores_start", {30'd0, state}, 3);
    c0 = clrs;
    press(3'b100);
    check("done_exit_idle", {30'd0, state}, 0);
    check("done_exit_flag", {31'd0, done}, 0);
    check("done_exit_clr", clrs - c0, 1);
    press(3'b010);
    press(3'b001);
    k = 0;
    while (val < 3 && k < 100) begin step(1); k++; end
    press(3'b001);
    press(3'b010);
    btn_start = 1;
    wait_en(60);
    #1 rst = 1;
    #1 check("async_reset", {27'd0, state, done, cnt_en, cnt_dir, cnt_clr}, 0);
    btn_start = 0;
    step(2);
    rst = 0;
    step(5);
    check("post_reset_idle", {30'd0, state}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
